// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int MAX_DBURST_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between fetch port, load/store port, arbiter and memory.
// Handshake: each req is held until its one-cycle ack; mem_req is held until the one-cycle mem_ack.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              busy;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    // Pipeline and memory view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

endinterface

// File: rtl/mem_arb_burst_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module mem_arb_burst_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && !sat) begin
            count <= count + 4'd1;
        end
    end

    assign sat = (count == 4'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data wins ties unless MAX_DBURST data grants in a row have starved a pending fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DBURST = MAX_DBURST_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output arb_state_e          dbg_state
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              owner;
    logic              grant_d;
    logic              grant_if;
    logic              load;
    logic              dburst_sat;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE, so a requester that still holds
    // req during RESP cannot be granted a second time.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                grant_d  = bus.d_req && !(bus.if_req && dburst_sat);
                grant_if = !grant_d && bus.if_req;
                if (grant_d || grant_if) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load = grant_d || grant_if;

    mem_arb_burst_ctr #(
        .MAX (MAX_DBURST)
    ) u_burst_ctr (
        .clk (clk),
        .rst (rst),
        .inc (grant_d && bus.if_req),
        .clr (grant_if || (grant_d && !bus.if_req)),
        .sat (dburst_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= OWNER_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (load) begin
                mem_req_q <= 1'b1;
                if (grant_d) begin
                    owner       <= OWNER_D;
                    mem_we_q    <= bus.d_we;
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                    mem_be_q    <= bus.d_be;
                end else begin
                    owner       <= OWNER_IF;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.if_addr;
                    mem_wdata_q <= '0;
                    mem_be_q    <= 4'b0000;
                end
            end
            if (state == BUSY && bus.mem_ack) begin
                mem_req_q <= 1'b0;
                if (owner == OWNER_D) begin
                    d_rdata_q <= bus.mem_rdata;
                    d_ack_q   <= 1'b1;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                    if_ack_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state == BUSY) || (state == RESP);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    localparam int MODE_MANUAL = 0;
    localparam int MODE_HOLD   = 1;
    localparam int MODE_ONCE   = 2;
    localparam int MODE_RAND   = 3;
    localparam int MODE_DROP   = 4;

    typedef enum int {M_IDLE, M_BUSY, M_RESP} m_phase_e;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    arb_state_e dbg_state;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_DBURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    m_phase_e        m_phase = M_IDLE;
    int              m_dcnt = 0;
    bit              m_owner_d = 1'b0;
    bit              m_rst_edge = 1'b0;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [3:0]      m_be;
    logic [DW-1:0]   m_if_rdata = '0;
    logic [DW-1:0]   m_d_rdata = '0;

    // ---------------- environment knobs and observation ----------------
    int              if_mode = MODE_MANUAL;
    int              d_mode  = MODE_MANUAL;
    bit              mem_auto = 1'b1;
    bit              rand_lat = 1'b0;
    int              mem_lat = 1;
    int              mem_wait = 0;
    bit              fixed_en = 1'b0;
    logic [DW-1:0]   fixed_rdata = '0;

    int              n_if_ack, n_d_ack, n_memreq_cyc, n_grants;
    bit              prev_mem_req = 1'b0;
    int              ack_order[$];
    logic            seen_we;
    logic [AW-1:0]   seen_addr;
    logic [DW-1:0]   seen_wdata;
    logic [3:0]      seen_be;
    int              exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic clear_obs();
        n_if_ack     = 0;
        n_d_ack      = 0;
        n_memreq_cyc = 0;
        n_grants     = 0;
        ack_order.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic respond();
        if (mem_auto) begin
            if (bus.mem_req) begin
                mem_wait++;
                if (mem_wait >= mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = fixed_en ? fixed_rdata : DW'($urandom);
                    mem_wait      = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                mem_wait      = 0;
                if (rand_lat) mem_lat = $urandom_range(1, 4);
            end
        end
        case (if_mode)
            MODE_HOLD: if (bus.if_ack) new_if();
            MODE_ONCE: if (bus.if_ack) bus.if_req = 1'b0;
            MODE_RAND: begin
                if (bus.if_ack) begin
                    if ($urandom_range(0, 1) == 1) new_if();
                    else bus.if_req = 1'b0;
                end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                    new_if();
                end
            end
            default: ;
        endcase
        case (d_mode)
            MODE_HOLD: if (bus.d_ack) new_d();
            MODE_ONCE: if (bus.d_ack) bus.d_req = 1'b0;
            MODE_DROP: if (m_phase == M_BUSY && m_owner_d) bus.d_req = 1'b0;
            MODE_RAND: begin
                if (bus.d_ack) begin
                    if ($urandom_range(0, 1) == 1) new_d();
                    else bus.d_req = 1'b0;
                end else if (m_phase == M_BUSY && m_owner_d && $urandom_range(0, 7) == 0) begin
                    bus.d_req = 1'b0;
                end else if (!bus.d_req && $urandom_range(0, 1) == 0) begin
                    new_d();
                end
            end
            default: ;
        endcase
    endtask

    // One clock: advance the model with the inputs the DUT is about to sample,
    // then compare the DUT after the edge and let the environment react.
    task automatic step();
        bit gd;
        if (!rst) begin
            m_phase    = M_IDLE;
            m_dcnt     = 0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
            m_rst_edge = 1'b1;
        end else begin
            m_rst_edge = 1'b0;
            case (m_phase)
                M_IDLE: begin
                    if (bus.d_req || bus.if_req) begin
                        gd        = bus.d_req && !(bus.if_req && m_dcnt == MAXB);
                        m_owner_d = gd;
                        if (gd) begin
                            m_dcnt  = bus.if_req ? ((m_dcnt < MAXB) ? m_dcnt + 1 : MAXB) : 0;
                            m_we    = bus.d_we;
                            m_addr  = bus.d_addr;
                            m_wdata = bus.d_wdata;
                            m_be    = bus.d_be;
                        end else begin
                            m_dcnt  = 0;
                            m_we    = 1'b0;
                            m_addr  = bus.if_addr;
                            m_be    = 4'b0000;
                        end
                        m_phase = M_BUSY;
                    end
                end
                M_BUSY: begin
                    if (bus.mem_ack) begin
                        if (m_owner_d) m_d_rdata = bus.mem_rdata;
                        else m_if_rdata = bus.mem_rdata;
                        m_phase = M_RESP;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end

        @(posedge clk);
        #1;
        check("mem_req", bus.mem_req, m_phase == M_BUSY);
        check("busy", bus.busy, m_phase != M_IDLE);
        check("if_ack", bus.if_ack, m_phase == M_RESP && !m_owner_d);
        check("d_ack", bus.d_ack, m_phase == M_RESP && m_owner_d);
        check("if_rdata", bus.if_rdata, m_if_rdata);
        check("d_rdata", bus.d_rdata, m_d_rdata);
        if (m_phase == M_BUSY) begin
            check("mem_we", bus.mem_we, m_we);
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_be", bus.mem_be, m_be);
            if (m_owner_d) check("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (m_rst_edge) begin
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_mem_wdata", bus.mem_wdata, 0);
            check("rst_mem_be", bus.mem_be, 0);
        end

        if (bus.mem_req) begin
            n_memreq_cyc++;
            seen_we    = bus.mem_we;
            seen_addr  = bus.mem_addr;
            seen_wdata = bus.mem_wdata;
            seen_be    = bus.mem_be;
        end
        if (bus.mem_req && !prev_mem_req) n_grants++;
        prev_mem_req = bus.mem_req;
        if (bus.if_ack) begin
            n_if_ack++;
            ack_order.push_back(0);
        end
        if (bus.d_ack) begin
            n_d_ack++;
            ack_order.push_back(1);
        end
        respond();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = 4'b0000;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        clear_obs();

        // Reset held with both requests pending, then data/fetch fairness.
        rst = 1'b0;
        new_if();
        new_d();
        step();
        step();
        check("rst_state", dbg_state, IDLE);
        rst = 1'b1;
        clear_obs();
        if_mode = MODE_HOLD;
        d_mode  = MODE_HOLD;
        mem_lat = 1;
        repeat (30) step();
        check("fair_n_acks", ack_order.size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < ack_order.size()) check($sformatf("fair_order%0d", k), ack_order[k], exp_order[k]);
        end
        if_mode = MODE_ONCE;
        d_mode  = MODE_ONCE;
        repeat (10) step();
        if_mode = MODE_MANUAL;
        d_mode  = MODE_MANUAL;

        // Single fetch with two-cycle memory latency.
        clear_obs();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        if_mode     = MODE_ONCE;
        mem_lat     = 2;
        fixed_en    = 1'b1;
        fixed_rdata = 32'h00A0_0093;
        repeat (6) step();
        check("fetch_req_cycles", n_memreq_cyc, 2);
        check("fetch_we", seen_we, 1'b0);
        check("fetch_addr", seen_addr, 32'h0000_0010);
        check("fetch_n_if_ack", n_if_ack, 1);
        check("fetch_n_d_ack", n_d_ack, 0);
        check("fetch_rdata", bus.if_rdata, 32'h00A0_0093);
        fixed_en = 1'b0;
        if_mode  = MODE_MANUAL;

        // Store command passes through unchanged.
        clear_obs();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0104;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be    = 4'b0011;
        d_mode      = MODE_ONCE;
        mem_lat     = 1;
        repeat (6) step();
        check("store_we", seen_we, 1'b1);
        check("store_addr", seen_addr, 32'h0000_0104);
        check("store_wdata", seen_wdata, 32'hDEAD_BEEF);
        check("store_be", seen_be, 4'b0011);
        check("store_n_d_ack", n_d_ack, 1);
        check("store_n_if_ack", n_if_ack, 0);

        // Data request withdrawn while the access is in flight.
        clear_obs();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0200;
        d_mode     = MODE_DROP;
        mem_lat    = 3;
        repeat (8) step();
        check("drop_n_d_ack", n_d_ack, 1);
        check("drop_grants", n_grants, 1);
        check("drop_req_cycles", n_memreq_cyc, 3);
        check("drop_busy", bus.busy, 1'b0);
        check("drop_state", dbg_state, IDLE);
        d_mode = MODE_MANUAL;

        // Reset while BUSY, then a stale mem_ack right after release.
        clear_obs();
        mem_auto    = 1'b0;
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0400;
        step();
        step();
        check("midrst_req_before", bus.mem_req, 1'b1);
        rst        = 1'b0;
        bus.if_req = 1'b0;
        step();
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        step();
        bus.mem_ack = 1'b0;
        step();
        step();
        check("midrst_n_if_ack", n_if_ack, 0);
        check("midrst_n_d_ack", n_d_ack, 0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_if_rdata", bus.if_rdata, 0);

        // Random traffic with random memory latency.
        mem_auto = 1'b1;
        rand_lat = 1'b1;
        if_mode  = MODE_RAND;
        d_mode   = MODE_RAND;
        repeat (1500) step();
        if_mode = MODE_ONCE;
        d_mode  = MODE_ONCE;
        repeat (12) step();
        check("final_busy", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
